memory_access_unit: RTL and testbench

Load/store front end that sits directly upstream of the data RAM and consumes its read output. Accepts one load or store per request from the pipeline's memory stage and converts byte addresses into RAM word addresses. Performs byte and halfword load extraction with sign or zero extension, and read-modify-write for sub-word stores. Rejects out-of-range and misaligned accesses with an error response instead of touching the RAM.

---
 rtl/memory_access_unit.sv | 190 +++++++++++++++++++
 tb/tb_memory_access_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_unit.sv
// Load/store front end for a synchronous data RAM: byte/half/word loads with
// extension, read-modify-write for sub-word stores, and range/alignment faults.
module memory_access_unit #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_DEPTH  = 301
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [1:0]              req_size,
   input  logic                    req_signed,
   input  logic [ADDR_WIDTH+1:0]   req_address,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    resp_valid,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic                    resp_error,
   output logic [ADDR_WIDTH-1:0]   ram_address,
   output logic [DATA_WIDTH-1:0]   ram_data,
   output logic                    ram_write_enable,
   input  logic [DATA_WIDTH-1:0]   ram_read_data
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_READ_WAIT = 3'd1,
      ST_CAPTURE   = 3'd2,
      ST_WRITE     = 3'd3,
      ST_ERROR     = 3'd4
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(MEM_DEPTH - 1);

   state_t          state_r;
   state_t          state_next_s;
   logic            fault_s;
   logic            accept_s;
   logic            write_r;
   logic            signed_r;
   logic [1:0]      size_r;
   logic [1:0]      offset_r;
   logic [31:0]     wdata_r;

   // Little-endian lane select followed by sign or zero extension.
   function automatic logic [31:0] extract_lane(input logic [31:0] word, input logic [1:0] size,
                                                input logic sgn, input logic [1:0] offset);
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = word >> {offset, 3'b000};
      case (size)
         2'b00:   result = {{24{sgn & shifted[7]}}, shifted[7:0]};
         2'b01:   result = {{16{sgn & shifted[15]}}, shifted[15:0]};
         default: result = shifted;
      endcase
      return result;
   endfunction

   // Replace only the addressed lane(s) of the current RAM word.
   function automatic logic [31:0] merge_lanes(input logic [31:0] word, input logic [31:0] wdata,
                                               input logic [1:0] size, input logic [1:0] offset);
      logic [31:0] result;
      result = word;
      case (size)
         2'b00: begin
            case (offset)
               2'b00:   result[7:0]   = wdata[7:0];
               2'b01:   result[15:8]  = wdata[7:0];
               2'b10:   result[23:16] = wdata[7:0];
               default: result[31:24] = wdata[7:0];
            endcase
         end
         2'b01: begin
            if (offset[1]) begin
               result[31:16] = wdata[15:0];
            end else begin
               result[15:0] = wdata[15:0];
            end
         end
         default: result = wdata;
      endcase
      return result;
   endfunction

   assign accept_s  = req_valid && (state_r == ST_IDLE);
   assign req_ready = (state_r == ST_IDLE);

   // Range and alignment fault decode on the live request.
   always_comb begin
      fault_s = 1'b0;
      if (req_address[ADDR_WIDTH+1:2] > LAST_WORD) begin
         fault_s = 1'b1;
      end else if (req_size == 2'b11) begin
         fault_s = 1'b1;
      end else if ((req_size == 2'b01) && req_address[0]) begin
         fault_s = 1'b1;
      end else if ((req_size == 2'b10) && (req_address[1:0] != 2'b00)) begin
         fault_s = 1'b1;
      end else begin
         fault_s = 1'b0;
      end
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (fault_s) begin
                  state_next_s = ST_ERROR;
               end else if (req_write && (req_size == 2'b10)) begin
                  state_next_s = ST_WRITE;
               end else begin
                  state_next_s = ST_READ_WAIT;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_READ_WAIT: state_next_s = ST_CAPTURE;
         ST_CAPTURE: begin
            if (write_r) begin
               state_next_s = ST_WRITE;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_WRITE: state_next_s = ST_IDLE;
         ST_ERROR: state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // Response outputs; load data is only valid while the RAM output is in CAPTURE.
   always_comb begin
      resp_valid = 1'b0;
      resp_error = 1'b0;
      resp_rdata = 32'h0000_0000;
      case (state_r)
         ST_CAPTURE: begin
            if (!write_r) begin
               resp_valid = 1'b1;
               resp_rdata = extract_lane(ram_read_data, size_r, signed_r, offset_r);
            end else begin
               resp_valid = 1'b0;
            end
         end
         ST_WRITE: resp_valid = 1'b1;
         ST_ERROR: begin
            resp_valid = 1'b1;
            resp_error = 1'b1;
         end
         default: resp_valid = 1'b0;
      endcase
   end

   // State, request latch and registered RAM interface.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r          <= ST_IDLE;
         ram_address      <= '0;
         ram_data         <= 32'h0000_0000;
         ram_write_enable <= 1'b0;
         write_r          <= 1'b0;
         signed_r         <= 1'b0;
         size_r           <= 2'b00;
         offset_r         <= 2'b00;
         wdata_r          <= 32'h0000_0000;
      end else begin
         state_r          <= state_next_s;
         ram_write_enable <= (state_next_s == ST_WRITE);
         if (accept_s) begin
            ram_address <= req_address[ADDR_WIDTH+1:2];
            write_r     <= req_write;
            signed_r    <= req_signed;
            size_r      <= req_size;
            offset_r    <= req_address[1:0];
            wdata_r     <= req_wdata;
            if (!fault_s && req_write && (req_size == 2'b10)) begin
               ram_data <= req_wdata;
            end
         end else if ((state_r == ST_CAPTURE) && write_r) begin
            ram_data <= merge_lanes(ram_read_data, wdata_r, size_r, offset_r);
         end
      end
   end

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit: RAM model, directed scenarios and
// randomized requests against an arithmetic reference model of memory contents.
module tb_memory_access_unit;

   logic        clock;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [11:0] req_address;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [9:0]  ram_address;
   logic [31:0] ram_data;
   logic        ram_write_enable;
   logic [31:0] ram_read_data;

   logic [31:0] ram_mem [0:1023];
   logic [31:0] ref_mem [0:1023];
   int n_checks = 0;
   int n_errors = 0;

   memory_access_unit #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .MEM_DEPTH(301)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
      .req_address(req_address), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_error(resp_error), .ram_address(ram_address),
      .ram_data(ram_data), .ram_write_enable(ram_write_enable), .ram_read_data(ram_read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous RAM: registered read, write committed at the falling edge.
   always @(posedge clock) ram_read_data <= ram_mem[ram_address];
   always @(negedge clock) if (ram_write_enable === 1'b1) ram_mem[ram_address] = ram_data;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: expected outcome of one request from byte-addressing arithmetic.
   task automatic ref_access(input logic w, input logic [1:0] sz, input logic sg, input logic [11:0] a,
                             input logic [31:0] wd, output int lat, output logic [31:0] rd,
                             output logic er, output int wes, output logic [31:0] wdat);
      int idx, off, nbytes, bits;
      logic [31:0] mask, v, lowmask;
      idx = int'(a) / 4;
      off = int'(a) % 4;
      er = (idx > 300) || (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
      rd = 32'h0; wes = 0; wdat = 32'h0;
      nbytes = 1 << sz;
      bits = 8 * nbytes;
      if (er) begin
         lat = 1;
      end else if (w) begin
         lowmask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << bits) - 32'h1);
         mask = lowmask << (8 * off);
         ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wd << (8 * off)) & mask);
         wdat = ref_mem[idx];
         wes = 1;
         lat = (sz == 2'd2) ? 1 : 3;
      end else begin
         v = ref_mem[idx] >> (8 * off);
         lat = 2;
         if (nbytes == 4) begin
            rd = v;
         end else begin
            lowmask = (32'h1 << bits) - 32'h1;
            rd = v & lowmask;
            if (sg && rd[bits-1]) rd = rd | ~lowmask;
         end
      end
   endtask

   // Drive one request, wait for acceptance, observe the RAM side and the response.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg, input logic [11:0] a,
                        input logic [31:0] wd, output int lat, output logic [31:0] rd, output logic er,
                        output int wes, output int we_lat, output logic [31:0] we_data,
                        output logic [9:0] addr_seen, output logic addr_held);
      int waited;
      lat = -1; rd = 32'h0; er = 1'b0; wes = 0; we_lat = -1; we_data = 32'h0;
      addr_seen = 10'h0; addr_held = 1'b1;
      @(negedge clock);
      req_write = w; req_size = sz; req_signed = sg; req_address = a; req_wdata = wd;
      req_valid = 1'b1;
      waited = 0;
      while (req_ready !== 1'b1 && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      @(posedge clock);
      #1 req_valid = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clock);
         if (c == 1) addr_seen = ram_address;
         else if (ram_address !== addr_seen) addr_held = 1'b0;
         if (ram_write_enable === 1'b1) begin
            wes++;
            we_lat = c;
            we_data = ram_data;
         end
         if (resp_valid === 1'b1) begin
            lat = c; rd = resp_rdata; er = resp_error;
            break;
         end
      end
      @(negedge clock);
      if (ram_write_enable === 1'b1) wes++;
   endtask

   task automatic test_reset;
      reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
      req_signed = 1'b0; req_address = 12'h010; req_wdata = 32'h1234_5678;
      repeat (3) @(posedge clock);
      @(negedge clock);
      n_checks++; if (req_ready !== 1'b1) begin n_errors++; $display("FAIL rst_ready: got %b want 1", req_ready); end
      n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
      n_checks++; if (resp_error !== 1'b0 || resp_rdata !== 32'h0) begin n_errors++; $display("FAIL rst_resp: got err=%b data=%h want 0", resp_error, resp_rdata); end
      n_checks++; if (ram_write_enable !== 1'b0) begin n_errors++; $display("FAIL rst_we: got %b want 0", ram_write_enable); end
      n_checks++; if (ram_address !== 10'h0 || ram_data !== 32'h0) begin n_errors++; $display("FAIL rst_ram: got addr=%h data=%h want 0", ram_address, ram_data); end
      req_valid = 1'b0; reset = 1'b0;
      @(negedge clock);
      n_checks++; if (req_ready !== 1'b1 || ram_write_enable !== 1'b0 || resp_valid !== 1'b0) begin
         n_errors++; $display("FAIL rst_priority: got ready=%b we=%b rv=%b want 1/0/0", req_ready, ram_write_enable, resp_valid);
      end
   endtask

   task automatic test_word_store_load;
      int lat, wes, wl, el, ew; logic [31:0] rd, wdat, ed, edat; logic er, held, ee; logic [9:0] as;
      ref_access(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, el, ed, ee, ew, edat);
      issue(1'b1, 2'b10, 1'b0, 12'h010, 32'hDEAD_BEEF, lat, rd, er, wes, wl, wdat, as, held);
      n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL ws_latency: got %0d want 1", lat); end
      n_checks++; if (wes !== 1 || wl !== 1) begin n_errors++; $display("FAIL ws_we: got count=%0d at %0d want 1 at 1", wes, wl); end
      n_checks++; if (as !== 10'd4 || wdat !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL ws_ram: got addr=%0d data=%h want 4 deadbeef", as, wdat); end
      n_checks++; if (er !== 1'b0 || rd !== 32'h0) begin n_errors++; $display("FAIL ws_resp: got err=%b data=%h want 0 0", er, rd); end
      ref_access(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, el, ed, ee, ew, edat);
      issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, rd, er, wes, wl, wdat, as, held);
      n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL wl_latency: got %0d want 2", lat); end
      n_checks++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_errors++; $display("FAIL wl_data: got %h err=%b want deadbeef 0", rd, er); end
      n_checks++; if (wes !== 0) begin n_errors++; $display("FAIL wl_no_we: got %0d want 0", wes); end
   endtask

   task automatic test_subword_load;
      logic [11:0] addrs [3] = '{12'h012, 12'h013, 12'h010};
      logic [1:0]  sizes [3] = '{2'b00, 2'b00, 2'b01};
      logic        sgns  [3] = '{1'b1, 1'b0, 1'b1};
      logic [31:0] wants [3] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01};
      int lat, wes, wl, el, ew; logic [31:0] rd, wdat, ed, edat; logic er, held, ee; logic [9:0] as;
      ref_access(1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF_7F01, el, ed, ee, ew, edat);
      issue(1'b1, 2'b10, 1'b0, 12'h010, 32'h80FF_7F01, lat, rd, er, wes, wl, wdat, as, held);
      for (int i = 0; i < 3; i++) begin
         ref_access(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, el, ed, ee, ew, edat);
         issue(1'b0, sizes[i], sgns[i], addrs[i], 32'h0, lat, rd, er, wes, wl, wdat, as, held);
         n_checks++; if (rd !== wants[i] || lat !== 2 || er !== 1'b0) begin
            n_errors++; $display("FAIL subload_%0d: got data=%h lat=%0d err=%b want %h 2 0", i, rd, lat, er, wants[i]);
         end
      end
   endtask

   task automatic test_subword_store;
      int lat, wes, wl, el, ew; logic [31:0] rd, wdat, ed, edat; logic er, held, ee; logic [9:0] as;
      ref_access(1'b1, 2'b10, 1'b0, 12'h014, 32'h1122_3344, el, ed, ee, ew, edat);
      issue(1'b1, 2'b10, 1'b0, 12'h014, 32'h1122_3344, lat, rd, er, wes, wl, wdat, as, held);
      ref_access(1'b1, 2'b00, 1'b0, 12'h015, 32'h0000_00AA, el, ed, ee, ew, edat);
      issue(1'b1, 2'b00, 1'b0, 12'h015, 32'h0000_00AA, lat, rd, er, wes, wl, wdat, as, held);
      n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL bs_latency: got %0d want 3", lat); end
      n_checks++; if (wes !== 1 || wl !== 3) begin n_errors++; $display("FAIL bs_we: got count=%0d at %0d want 1 at 3", wes, wl); end
      n_checks++; if (wdat !== 32'h1122_AA44 || as !== 10'd5) begin n_errors++; $display("FAIL bs_merge: got %h addr=%0d want 1122aa44 5", wdat, as); end
      n_checks++; if (held !== 1'b1) begin n_errors++; $display("FAIL bs_addr_hold: got %b want 1", held); end
      issue(1'b0, 2'b10, 1'b0, 12'h014, 32'h0, lat, rd, er, wes, wl, wdat, as, held);
      n_checks++; if (rd !== 32'h1122_AA44) begin n_errors++; $display("FAIL bs_readback: got %h want 1122aa44", rd); end
   endtask

   task automatic test_faults;
      logic        ws [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [1:0]  ss [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
      logic [11:0] as_t [4] = '{12'h011, 12'h012, 12'h010, 12'h4B4};
      int lat, wes, wl, el, ew; logic [31:0] rd, wdat, ed, edat; logic er, held, ee; logic [9:0] as;
      for (int i = 0; i < 4; i++) begin
         issue(ws[i], ss[i], 1'b0, as_t[i], 32'hCAFE_F00D, lat, rd, er, wes, wl, wdat, as, held);
         n_checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0 || wes !== 0) begin
            n_errors++; $display("FAIL fault_%0d: got lat=%0d err=%b data=%h we=%0d want 1 1 0 0", i, lat, er, rd, wes);
         end
      end
      ref_access(1'b0, 2'b10, 1'b0, 12'h4B0, 32'h0, el, ed, ee, ew, edat);
      issue(1'b0, 2'b10, 1'b0, 12'h4B0, 32'h0, lat, rd, er, wes, wl, wdat, as, held);
      n_checks++; if (lat !== 2 || er !== 1'b0 || rd !== ref_mem[300]) begin
         n_errors++; $display("FAIL last_word: got lat=%0d err=%b data=%h want 2 0 %h", lat, er, rd, ref_mem[300]);
      end
      issue(1'b0, 2'b10, 1'b0, 12'h010, 32'h0, lat, rd, er, wes, wl, wdat, as, held);
      n_checks++; if (rd !== ref_mem[4]) begin n_errors++; $display("FAIL fault_no_write: got %h want %h", rd, ref_mem[4]); end
   endtask

   task automatic test_reset_mid;
      int lat, wes, wl, el, ew; logic [31:0] rd, wdat, ed, edat; logic er, held, ee; logic [9:0] as;
      logic seen;
      for (int k = 1; k <= 2; k++) begin
         @(negedge clock);
         req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0; req_address = 12'h019;
         req_wdata = $urandom; req_valid = 1'b1;
         @(posedge clock);
         #1 req_valid = 1'b0;
         repeat (k) @(negedge clock);
         reset = 1'b1;
         @(posedge clock);
         #1 reset = 1'b0;
         @(negedge clock);
         n_checks++; if (ram_write_enable !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_errors++; $display("FAIL midrst_%0d_ctrl: got we=%b rv=%b ready=%b want 0 0 1", k, ram_write_enable, resp_valid, req_ready);
         end
         n_checks++; if (ram_address !== 10'h0 || ram_data !== 32'h0 || resp_rdata !== 32'h0 || resp_error !== 1'b0) begin
            n_errors++; $display("FAIL midrst_%0d_zero: got addr=%h data=%h rdata=%h err=%b want 0", k, ram_address, ram_data, resp_rdata, resp_error);
         end
         seen = 1'b0;
         repeat (5) begin
            @(negedge clock);
            if (ram_write_enable === 1'b1 || resp_valid === 1'b1) seen = 1'b1;
         end
         n_checks++; if (seen !== 1'b0) begin n_errors++; $display("FAIL midrst_%0d_quiet: got activity=%b want 0", k, seen); end
      end
      ref_access(1'b0, 2'b10, 1'b0, 12'h018, 32'h0, el, ed, ee, ew, edat);
      issue(1'b0, 2'b10, 1'b0, 12'h018, 32'h0, lat, rd, er, wes, wl, wdat, as, held);
      n_checks++; if (rd !== ed) begin n_errors++; $display("FAIL midrst_unwritten: got %h want %h", rd, ed); end
   endtask

   task automatic test_back_to_back;
      localparam int N = 8;
      logic        bw [N]; logic [1:0] bs [N]; logic bg [N]; logic [11:0] ba [N]; logic [31:0] bd [N];
      logic [31:0] exp_rd_q [$]; logic exp_er_q [$];
      int el, ew, idx_drive, n_resp; logic [31:0] ed, edat; logic ee, rdy;
      for (int i = 0; i < N; i++) begin
         bw[i] = 1'($urandom % 2); bs[i] = 2'($urandom % 3); bg[i] = 1'($urandom % 2);
         bd[i] = $urandom;
         ba[i] = 12'(40 + 4 * ($urandom % 4));
         if (bs[i] == 2'b00) ba[i] = ba[i] + 12'($urandom % 4);
         else if (bs[i] == 2'b01) ba[i] = ba[i] + 12'(2 * ($urandom % 2));
      end
      idx_drive = 0; n_resp = 0;
      for (int cyc = 0; cyc < 200 && n_resp < N; cyc++) begin
         @(negedge clock);
         rdy = req_ready;
         n_checks++; if (rdy !== (idx_drive == n_resp)) begin
            n_errors++; $display("FAIL b2b_ready: got %b want %b at cycle %0d", rdy, (idx_drive == n_resp), cyc);
         end
         if (resp_valid === 1'b1) begin
            n_checks++;
            if (exp_rd_q.size() == 0) begin
               n_errors++; $display("FAIL b2b_extra_resp: got response want none");
            end else begin
               ed = exp_rd_q.pop_front(); ee = exp_er_q.pop_front();
               if (resp_rdata !== ed || resp_error !== ee) begin
                  n_errors++; $display("FAIL b2b_resp_%0d: got %h err=%b want %h %b", n_resp, resp_rdata, resp_error, ed, ee);
               end
            end
            n_resp++;
         end
         if (idx_drive < N) begin
            req_write = bw[idx_drive]; req_size = bs[idx_drive]; req_signed = bg[idx_drive];
            req_address = ba[idx_drive]; req_wdata = bd[idx_drive]; req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clock);
         if (rdy && req_valid) begin
            ref_access(bw[idx_drive], bs[idx_drive], bg[idx_drive], ba[idx_drive], bd[idx_drive], el, ed, ee, ew, edat);
            exp_rd_q.push_back(ed); exp_er_q.push_back(ee);
            idx_drive++;
         end
      end
      req_valid = 1'b0;
      n_checks++; if (n_resp !== N || idx_drive !== N) begin
         n_errors++; $display("FAIL b2b_count: got accepted=%0d responses=%0d want %0d", idx_drive, n_resp, N);
      end
   endtask

   task automatic test_random;
      logic w, sg, er, held, ee; logic [1:0] sz; logic [11:0] a; logic [31:0] wd, rd, wdat, ed, edat;
      int lat, wes, wl, el, ew; logic [9:0] as;
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom % 2); sz = 2'($urandom % 4); sg = 1'($urandom % 2);
         a = 12'($urandom_range(0, 12'h4C3)); wd = $urandom;
         if (i % 3 == 0) a = 12'(4 * ($urandom % 8));
         ref_access(w, sz, sg, a, wd, el, ed, ee, ew, edat);
         issue(w, sz, sg, a, wd, lat, rd, er, wes, wl, wdat, as, held);
         n_checks++; if (lat !== el) begin n_errors++; $display("FAIL rnd_%0d_latency: got %0d want %0d", i, lat, el); end
         n_checks++; if (rd !== ed || er !== ee) begin n_errors++; $display("FAIL rnd_%0d_resp: got %h err=%b want %h %b", i, rd, er, ed, ee); end
         n_checks++; if (wes !== ew) begin n_errors++; $display("FAIL rnd_%0d_we_count: got %0d want %0d", i, wes, ew); end
         n_checks++; if (as !== a[11:2] || held !== 1'b1) begin n_errors++; $display("FAIL rnd_%0d_addr: got %h held=%b want %h 1", i, as, held, a[11:2]); end
         if (ew == 1) begin
            n_checks++; if (wdat !== edat || wl !== el) begin
               n_errors++; $display("FAIL rnd_%0d_wdata: got %h at %0d want %h at %0d", i, wdat, wl, edat, el);
            end
         end
      end
   endtask

   initial begin
      logic [31:0] v;
      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_signed = 1'b0; req_address = 12'h000; req_wdata = 32'h0;
      for (int i = 0; i < 1024; i++) begin
         v = $urandom;
         ram_mem[i] = v;
         ref_mem[i] = v;
      end
      test_reset();
      test_word_store_load();
      test_subword_load();
      test_subword_store();
      test_faults();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
